// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder
// ----------------------------------------------------------------------------
// Multi-cycle 64-bit data-memory responder for the core's load/store port.
// One request is accepted at a time over a valid/ready handshake. The request
// is answered after a fixed access latency, and the response is held until
// the core takes it.
//
// Optional feature macro: DMEM_ALIGN_CHK_EN
//   defined   : a request with addr[2:0] != 0 reports resp_err = 1. A
//               misaligned store leaves memory untouched, and a misaligned
//               load returns 0.
//   undefined : addr[2:0] is ignored, so the access uses the containing
//               doubleword, and resp_err stays 0.
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int ADDR_W      = 10,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err
);

    // ------------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------------
    localparam int IDX_W = ADDR_W - 3;
    localparam int CNT_W = 4;    // covers the whole 1..15 latency range

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // ------------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------------
    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             we_q,     we_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [63:0]      wdata_q,  wdata_d;
    logic [63:0]      rdata_q,  rdata_d;
    logic             err_q,    err_d;

    logic [63:0]      mem_q [DEPTH_WORDS];

    logic             accept_s;
    logic             commit_s;
    logic             misaligned_s;
    logic             mem_we_s;

`ifdef DMEM_ALIGN_CHK_EN
    logic [2:0]       off_q,    off_d;
`else
    // The byte offset has no function when alignment checking is compiled out.
    logic             unused_addr_off_s;
    assign unused_addr_off_s = ^req_addr[2:0];
`endif

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    // req_ready is gated by reset so that no request can be accepted while
    // reset is held.
    assign req_ready  = (state_q == S_IDLE) && !reset;
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign accept_s   = req_valid && req_ready;

    // Next-state logic: FSM, latency counter and request capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
`ifdef DMEM_ALIGN_CHK_EN
        off_d   = off_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    we_d    = req_we;
                    idx_d   = req_addr[ADDR_W-1:3];
                    wdata_d = req_wdata;
`ifdef DMEM_ALIGN_CHK_EN
                    off_d   = req_addr[2:0];
`endif
                    cnt_d   = CNT_LOAD;
                    if (LATENCY > 1) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_RESP;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Commit decode. The commit edge is the edge that enters RESP. The _d
    // copies of the request are used because with LATENCY == 1 the commit
    // edge is also the acceptance edge.
    always_comb begin
        commit_s = (state_d == S_RESP) && (state_q != S_RESP);
`ifdef DMEM_ALIGN_CHK_EN
        misaligned_s = (off_d != 3'd0);
`else
        misaligned_s = 1'b0;
`endif
        mem_we_s = commit_s && we_d && !misaligned_s;
    end

    // Response data and error: loaded at the commit edge, then held.
    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (commit_s) begin
            err_d = misaligned_s;
            if (we_d || misaligned_s) begin
                rdata_d = 64'd0;
            end else begin
                rdata_d = mem_q[idx_d];
            end
        end else begin
            rdata_d = rdata_q;
            err_d   = err_q;
        end
    end

    // Control and response registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            we_q    <= 1'b0;
            idx_q   <= {IDX_W{1'b0}};
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
`ifdef DMEM_ALIGN_CHK_EN
            off_q   <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef DMEM_ALIGN_CHK_EN
            off_q   <= off_d;
`endif
        end
    end

    // Doubleword storage: cleared by reset, written on a store's commit edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= 64'd0;
            end
        end else begin
            if (mem_we_s) begin
                mem_q[idx_d] <= wdata_d;
            end
        end
    end

endmodule
